// File: rtl/matrix_adjugate_3x3_seq_if.sv
// rtl/matrix_adjugate_3x3_seq_if.sv - start/done and matrix/result bundle for the 3x3 adjugate unit
interface matrix_adjugate_3x3_seq_if #(
  parameter int DW = 9,
  parameter int MW = 2 * DW,
  parameter int TW = 3 * DW + 1
);
  logic                 istart;
  logic signed [DW-1:0] iData_a11, iData_a12, iData_a13;
  logic signed [DW-1:0] iData_a21, iData_a22, iData_a23;
  logic signed [DW-1:0] iData_a31, iData_a32, iData_a33;
  logic                 obusy;
  logic                 odone;
  logic signed [MW-1:0] oadj11, oadj12, oadj13;
  logic signed [MW-1:0] oadj21, oadj22, oadj23;
  logic signed [MW-1:0] oadj31, oadj32, oadj33;
  logic signed [TW-1:0] odet;
  logic                 osingular;

  modport master (
    output istart,
    output iData_a11, iData_a12, iData_a13,
    output iData_a21, iData_a22, iData_a23,
    output iData_a31, iData_a32, iData_a33,
    input  obusy, odone,
    input  oadj11, oadj12, oadj13, oadj21, oadj22, oadj23, oadj31, oadj32, oadj33,
    input  odet, osingular
  );

  modport slave (
    input  istart,
    input  iData_a11, iData_a12, iData_a13,
    input  iData_a21, iData_a22, iData_a23,
    input  iData_a31, iData_a32, iData_a33,
    output obusy, odone,
    output oadj11, oadj12, oadj13, oadj21, oadj22, oadj23, oadj31, oadj32, oadj33,
    output odet, osingular
  );
endinterface

// File: rtl/matrix_adjugate_3x3_seq.sv
// rtl/matrix_adjugate_3x3_seq.sv - sequential 3x3 adjugate and determinant with one shared multiplier
module matrix_adjugate_3x3_seq #(
  parameter int DW = 9,
  parameter int MW = 2 * DW,
  parameter int TW = 3 * DW + 1
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  matrix_adjugate_3x3_seq_if.slave bus
);
  localparam int PW = MW + DW;

  typedef enum logic [1:0] {S_IDLE, S_MINOR, S_DET, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q;
  logic signed [DW-1:0] a_q   [0:8];
  logic signed [MW-1:0] cof_q [0:8];
  logic signed [MW-1:0] adj_q [0:8];
  logic signed [PW-1:0] acc_q;
  logic signed [TW-1:0] det_acc_q, det_q, det_next;
  logic                 sing_q;

  logic [3:0]           mi;
  logic [15:0]          sel;
  logic signed [PW-1:0] op_x, op_y, prod;

  assign mi = cnt_q[4:1];

  // Element indices {diag0, diag1, anti0, anti1} of the 2x2 submatrix for minor mi
  always_comb begin
    sel = 16'h4857;
    case (mi)
      4'd0:    sel = 16'h4857;
      4'd1:    sel = 16'h3856;
      4'd2:    sel = 16'h3746;
      4'd3:    sel = 16'h1827;
      4'd4:    sel = 16'h0826;
      4'd5:    sel = 16'h0716;
      4'd6:    sel = 16'h1524;
      4'd7:    sel = 16'h0523;
      4'd8:    sel = 16'h0413;
      default: sel = 16'h4857;
    endcase
  end

  always_comb begin
    op_x = '0;
    op_y = '0;
    case (state_q)
      S_MINOR: begin
        if (!cnt_q[0]) begin
          op_x = PW'(a_q[sel[15:12]]);
          op_y = PW'(a_q[sel[11:8]]);
        end else begin
          op_x = PW'(a_q[sel[7:4]]);
          op_y = PW'(a_q[sel[3:0]]);
        end
      end
      S_DET: begin
        op_x = PW'(cof_q[cnt_q[1:0]]);
        op_y = PW'(a_q[cnt_q[1:0]]);
      end
      default: ;
    endcase
  end

  assign prod     = op_x * op_y;
  assign det_next = det_acc_q + TW'(prod);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.istart) state_d = S_MINOR;
      S_MINOR: if (cnt_q == 5'd17) state_d = S_DET;
      S_DET:   if (cnt_q == 5'd2) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      det_acc_q <= '0;
      det_q     <= '0;
      sing_q    <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        a_q[k]   <= '0;
        cof_q[k] <= '0;
        adj_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.istart) begin
            a_q[0] <= bus.iData_a11; a_q[1] <= bus.iData_a12; a_q[2] <= bus.iData_a13;
            a_q[3] <= bus.iData_a21; a_q[4] <= bus.iData_a22; a_q[5] <= bus.iData_a23;
            a_q[6] <= bus.iData_a31; a_q[7] <= bus.iData_a32; a_q[8] <= bus.iData_a33;
            cnt_q     <= '0;
            det_acc_q <= '0;
          end
        end
        S_MINOR: begin
          if (!cnt_q[0]) acc_q <= prod;
          // Odd minor index means (i+j) odd, so the cofactor is the negated minor
          else if (mi[0]) cof_q[mi] <= MW'(prod - acc_q);
          else            cof_q[mi] <= MW'(acc_q - prod);
          cnt_q <= (cnt_q == 5'd17) ? 5'd0 : cnt_q + 5'd1;
        end
        S_DET: begin
          det_acc_q <= det_next;
          cnt_q     <= cnt_q + 5'd1;
          // Results are loaded on the last DET edge so they are valid while odone is high
          if (cnt_q == 5'd2) begin
            cnt_q  <= '0;
            det_q  <= det_next;
            sing_q <= (det_next == '0);
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                adj_q[i*3+j] <= cof_q[j*3+i];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.obusy     = (state_q != S_IDLE);
  assign bus.odone     = (state_q == S_DONE);
  assign bus.oadj11    = adj_q[0];
  assign bus.oadj12    = adj_q[1];
  assign bus.oadj13    = adj_q[2];
  assign bus.oadj21    = adj_q[3];
  assign bus.oadj22    = adj_q[4];
  assign bus.oadj23    = adj_q[5];
  assign bus.oadj31    = adj_q[6];
  assign bus.oadj32    = adj_q[7];
  assign bus.oadj33    = adj_q[8];
  assign bus.odet      = det_q;
  assign bus.osingular = sing_q;
endmodule
